// File: rtl/pong_pkg.sv
// Shared playfield geometry and game-state encoding for the pong datapath.
// Sums are widened by one bit so edge arithmetic never wraps.
package pong_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 8;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;
    localparam int PADDLE_XL = 16;
    localparam int PADDLE_XR = 616;
    localparam int POS_W     = 10;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   pos_ext_t;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    function automatic pos_ext_t ext(input pos_t v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/paddle_hit.sv
// Combinational overlap test between the ball and one paddle, qualified by
// the ball moving toward that paddle so a reversed ball cannot re-hit.
module paddle_hit
    import pong_pkg::*;
#(
    parameter bit RIGHT = 1'b0
) (
    input  logic [POS_W-1:0] bx,
    input  logic [POS_W-1:0] by,
    input  logic             bx_dir,
    input  logic [POS_W-1:0] py,
    output logic             hit
);

    localparam pos_ext_t PX    = pos_ext_t'(RIGHT ? PADDLE_XR : PADDLE_XL);
    localparam pos_ext_t PX_HI = pos_ext_t'((RIGHT ? PADDLE_XR : PADDLE_XL) + PADDLE_W);
    localparam pos_ext_t BALL  = pos_ext_t'(BALL_SIZE);
    localparam pos_ext_t PAD_H = pos_ext_t'(PADDLE_H);

    logic toward;
    logic x_overlap;
    logic y_overlap;

    always_comb begin
        toward    = (bx_dir == RIGHT);
        x_overlap = (ext(bx) <= PX_HI) && ((ext(bx) + BALL) > PX);
        y_overlap = ((ext(by) + BALL) > ext(py)) && (ext(by) < (ext(py) + PAD_H));
        hit       = toward && x_overlap && y_overlap;
    end

endmodule

// File: rtl/collision_detect.sv
// Per-tick wall/paddle/goal detection feeding ball_movement, plus scoring
// and the SERVE -> PLAY -> GAME_OVER sequencing.
module collision_detect
    import pong_pkg::*;
#(
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             counter,
    input  logic [POS_W-1:0] bx,
    input  logic [POS_W-1:0] by,
    input  logic             bx_dir,
    input  logic             by_dir,
    input  logic [POS_W-1:0] lp_y,
    input  logic [POS_W-1:0] rp_y,
    output logic             paddle_collision,
    output logic             wall_collision,
    output logic             serve,
    output logic [3:0]       score_l,
    output logic [3:0]       score_r,
    output logic             game_over
);

    localparam int       TICK_W    = $clog2(SERVE_TICKS);
    localparam pos_ext_t WALL_LOW  = pos_ext_t'(SCREEN_H - BALL_SIZE);
    localparam pos_ext_t GOAL_R    = pos_ext_t'(SCREEN_W - BALL_SIZE);
    localparam logic [3:0] WIN     = 4'(WIN_SCORE);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SERVE_TICKS - 1);

    game_state_t       state_reg, state_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [3:0]        score_l_reg, score_l_next;
    logic [3:0]        score_r_reg, score_r_next;
    logic              paddle_reg, paddle_next;
    logic              wall_reg, wall_next;

    logic hit_l, hit_r, wall_hit, point_l, point_r;

    paddle_hit #(.RIGHT(1'b0)) u_hit_l (
        .bx(bx), .by(by), .bx_dir(bx_dir), .py(lp_y), .hit(hit_l)
    );

    paddle_hit #(.RIGHT(1'b1)) u_hit_r (
        .bx(bx), .by(by), .bx_dir(bx_dir), .py(rp_y), .hit(hit_r)
    );

    // A miss on the left goal scores for the right player and vice versa;
    // a paddle hit on the same side always wins over the miss.
    always_comb begin
        wall_hit = (!by_dir && (by == '0)) || (by_dir && (ext(by) >= WALL_LOW));
        point_r  = !bx_dir && (bx == '0) && !hit_l;
        point_l  = bx_dir && (ext(bx) >= GOAL_R) && !hit_r;
    end

    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        score_l_next = score_l_reg;
        score_r_next = score_r_reg;
        paddle_next  = 1'b0;
        wall_next    = 1'b0;

        case (state_reg)
            SERVE: begin
                if (counter) begin
                    if (tick_reg == LAST_TICK) begin
                        state_next = PLAY;
                        tick_next  = '0;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (counter) begin
                    paddle_next = hit_l || hit_r;
                    tick_next   = '0;
                    if (point_r) begin
                        score_r_next = score_r_reg + 4'd1;
                        state_next   = (score_r_next == WIN) ? GAME_OVER : SERVE;
                    end else if (point_l) begin
                        score_l_next = score_l_reg + 4'd1;
                        state_next   = (score_l_next == WIN) ? GAME_OVER : SERVE;
                    end else begin
                        wall_next = wall_hit;
                    end
                end
            end
            GAME_OVER: ;
            default: state_next = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= SERVE;
            tick_reg    <= '0;
            score_l_reg <= '0;
            score_r_reg <= '0;
            paddle_reg  <= 1'b0;
            wall_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            score_l_reg <= score_l_next;
            score_r_reg <= score_r_next;
            paddle_reg  <= paddle_next;
            wall_reg    <= wall_next;
        end
    end

    assign paddle_collision = paddle_reg;
    assign wall_collision   = wall_reg;
    assign score_l          = score_l_reg;
    assign score_r          = score_r_reg;
    assign serve            = (state_reg != PLAY);
    assign game_over        = (state_reg == GAME_OVER);

endmodule
